// File: rtl/adrv9009_rsp_ctrl.sv
// Sequencer for the RHB3 -> RHB2 receive decimation chain: per-stage clock enables,
// filter reset while idle, and output-valid suppression during the start-up flush.
module adrv9009_rsp_ctrl #(
  parameter int FLUSH_SAMPLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic             bypass_rhb3,
  input  logic             bypass_rhb2,
  output logic             filt_rst,
  output logic             rhb3_ce,
  output logic             rhb2_ce,
  output logic             out_valid,
  output logic [2:0]       dec_ratio,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] out_cnt,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_SAMPLES - 1);

  state_t           state_q, state_n;
  logic             filt_rst_n;
  logic             rhb3_ce_n;
  logic             rhb2_ce_n;
  logic             out_valid_n;
  logic [2:0]       dec_ratio_n;
  logic [CNT_W-1:0] out_cnt_n;
  logic             cfg_err_n;
  logic             ph3_q, ph3_n;
  logic             ph2_q, ph2_n;
  logic [15:0]      flush_cnt_q, flush_cnt_n;
  logic             byp3_q, byp3_n;
  logic             byp2_q, byp2_n;
  logic [1:0]       byp_prev_q;
  logic             s2_tick;
  logic             out_tick;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      filt_rst    <= 1'b1;
      rhb3_ce     <= 1'b0;
      rhb2_ce     <= 1'b0;
      out_valid   <= 1'b0;
      dec_ratio   <= 3'd4;
      out_cnt     <= '0;
      cfg_err     <= 1'b0;
      ph3_q       <= 1'b0;
      ph2_q       <= 1'b0;
      flush_cnt_q <= '0;
      byp3_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp_prev_q  <= 2'b00;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge next-state values together.
      state_q     <= state_n;
      filt_rst    <= filt_rst_n;
      rhb3_ce     <= rhb3_ce_n;
      rhb2_ce     <= rhb2_ce_n;
      out_valid   <= out_valid_n;
      dec_ratio   <= dec_ratio_n;
      out_cnt     <= out_cnt_n;
      cfg_err     <= cfg_err_n;
      ph3_q       <= ph3_n;
      ph2_q       <= ph2_n;
      flush_cnt_q <= flush_cnt_n;
      byp3_q      <= byp3_n;
      byp2_q      <= byp2_n;
      byp_prev_q  <= {bypass_rhb3, bypass_rhb2};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n     = state_q;
    filt_rst_n  = filt_rst;
    rhb3_ce_n   = 1'b0;
    rhb2_ce_n   = 1'b0;
    out_valid_n = 1'b0;
    out_cnt_n   = out_cnt;
    cfg_err_n   = 1'b0;
    ph3_n       = ph3_q;
    ph2_n       = ph2_q;
    flush_cnt_n = flush_cnt_q;
    byp3_n      = byp3_q;
    byp2_n      = byp2_q;
    s2_tick     = 1'b0;
    out_tick    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        filt_rst_n = 1'b1;
        byp3_n     = bypass_rhb3;
        byp2_n     = bypass_rhb2;
        if (enable) begin
          state_n     = S_FLUSH;
          filt_rst_n  = 1'b0;
          ph3_n       = 1'b0;
          ph2_n       = 1'b0;
          flush_cnt_n = '0;
          out_cnt_n   = '0;
        end
      end

      S_FLUSH, S_RUN: begin
        // Config is frozen while running; an edge on the live inputs is only flagged.
        cfg_err_n = ({bypass_rhb3, bypass_rhb2} != byp_prev_q);
        if (!enable) begin
          state_n    = S_IDLE;
          filt_rst_n = 1'b1;
        end else if (in_valid) begin
          rhb3_ce_n = 1'b1;
          s2_tick   = byp3_q | ph3_q;
          ph3_n     = ~byp3_q & ~ph3_q;
          rhb2_ce_n = s2_tick;
          out_tick  = s2_tick & (byp2_q | ph2_q);
          if (s2_tick) begin
            ph2_n = ~byp2_q & ~ph2_q;
          end
          if (state_q == S_FLUSH) begin
            flush_cnt_n = flush_cnt_q + 16'd1;
            if (flush_cnt_q == FLUSH_LAST) begin
              state_n = S_RUN;
            end
          end else begin
            out_valid_n = out_tick;
            out_cnt_n   = out_cnt + CNT_W'(out_tick);
          end
        end
      end

      default: begin
        state_n    = S_IDLE;
        filt_rst_n = 1'b1;
      end
    endcase

    unique case ({byp3_n, byp2_n})
      2'b00:   dec_ratio_n = 3'd4;
      2'b11:   dec_ratio_n = 3'd1;
      default: dec_ratio_n = 3'd2;
    endcase
  end

endmodule

// File: tb/tb_adrv9009_rsp_ctrl.sv
// Directed self-checking bench for adrv9009_rsp_ctrl: decimation ratios, flush,
// config-change flag, enable drop/restart, async reset and out_cnt wrap.
module tb_adrv9009_rsp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, en_w, in_valid, bypass_rhb3, bypass_rhb2;
  logic       filt_rst, rhb3_ce, rhb2_ce, out_valid, cfg_err;
  logic [2:0] dec_ratio;
  logic [1:0] state;
  logic [15:0] out_cnt;
  logic       filt_rst_w, rhb3_ce_w, rhb2_ce_w, out_valid_w, cfg_err_w;
  logic [2:0] dec_ratio_w;
  logic [1:0] state_w;
  logic [3:0] out_cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adrv9009_rsp_ctrl #(.FLUSH_SAMPLES(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .bypass_rhb3(bypass_rhb3), .bypass_rhb2(bypass_rhb2),
    .filt_rst(filt_rst), .rhb3_ce(rhb3_ce), .rhb2_ce(rhb2_ce), .out_valid(out_valid),
    .dec_ratio(dec_ratio), .state(state), .out_cnt(out_cnt), .cfg_err(cfg_err)
  );

  adrv9009_rsp_ctrl #(.FLUSH_SAMPLES(4), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .enable(en_w), .in_valid(in_valid),
    .bypass_rhb3(bypass_rhb3), .bypass_rhb2(bypass_rhb2),
    .filt_rst(filt_rst_w), .rhb3_ce(rhb3_ce_w), .rhb2_ce(rhb2_ce_w), .out_valid(out_valid_w),
    .dec_ratio(dec_ratio_w), .state(state_w), .out_cnt(out_cnt_w), .cfg_err(cfg_err_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " state"},     32'(state), 32'(0));
    check({tag, " filt_rst"},  32'(filt_rst), 32'(1));
    check({tag, " rhb3_ce"},   32'(rhb3_ce), 32'(0));
    check({tag, " rhb2_ce"},   32'(rhb2_ce), 32'(0));
    check({tag, " out_valid"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; en_w = 1'b0; in_valid = 1'b0;
    bypass_rhb3 = 1'b0; bypass_rhb2 = 1'b0;
    tick(); tick();
    check_idle("reset");
    check("reset dec_ratio", 32'(dec_ratio), 32'(4));
    check("reset out_cnt", 32'(out_cnt), 32'(0));
    check("reset cfg_err", 32'(cfg_err), 32'(0));
    reset = 1'b0;
    tick();
    check_idle("idle");

    // Ratio 4, continuous input.
    enable = 1'b1;
    tick();
    check("start state", 32'(state), 32'(1));
    check("start filt_rst", 32'(filt_rst), 32'(0));
    check("start rhb3_ce", 32'(rhb3_ce), 32'(0));
    in_valid = 1'b1;
    for (int n = 1; n <= 104; n++) begin
      tick();
      check("r4 rhb3_ce", 32'(rhb3_ce), 32'(1));
      check("r4 rhb2_ce", 32'(rhb2_ce), 32'(n % 2 == 0));
      check("r4 out_valid", 32'(out_valid), 32'(n > 64 && n % 4 == 0));
      check("r4 state", 32'(state), (n >= 64) ? 32'(2) : 32'(1));
    end
    check("r4 out_cnt", 32'(out_cnt), 32'(10));
    check("r4 dec_ratio", 32'(dec_ratio), 32'(4));

    // Drop enable with in_valid high, then re-enable immediately.
    enable = 1'b0;
    tick();
    check_idle("drop");
    check("drop out_cnt hold", 32'(out_cnt), 32'(10));
    enable = 1'b1;
    tick();
    check("restart state", 32'(state), 32'(1));
    check("restart out_cnt", 32'(out_cnt), 32'(0));
    check("restart rhb3_ce", 32'(rhb3_ce), 32'(0));
    for (int n = 1; n <= 68; n++) begin
      tick();
      check("reflush out_valid", 32'(out_valid), 32'(n > 64 && n % 4 == 0));
      check("reflush state", 32'(state), (n >= 64) ? 32'(2) : 32'(1));
    end
    check("reflush out_cnt", 32'(out_cnt), 32'(1));

    // Bypass change while running: one flag pulse, cadence untouched.
    for (int n = 69; n <= 80; n++) begin
      if (n == 69) bypass_rhb2 = 1'b1;
      tick();
      check("cfg cfg_err", 32'(cfg_err), 32'(n == 69));
      check("cfg out_valid", 32'(out_valid), 32'(n % 4 == 0));
      check("cfg rhb2_ce", 32'(rhb2_ce), 32'(n % 2 == 0));
    end
    check("cfg dec_ratio", 32'(dec_ratio), 32'(4));
    check("cfg out_cnt", 32'(out_cnt), 32'(4));

    // Ratio 2 (RHB3 bypassed), input every 3rd cycle.
    enable = 1'b0; in_valid = 1'b0;
    tick();
    check_idle("stop2");
    bypass_rhb3 = 1'b1; bypass_rhb2 = 1'b0;
    tick();
    check("r2 dec_ratio idle", 32'(dec_ratio), 32'(2));
    check("r2 no cfg_err idle", 32'(cfg_err), 32'(0));
    enable = 1'b1;
    tick();
    check("r2 state", 32'(state), 32'(1));
    for (int n = 1; n <= 72; n++) begin
      in_valid = 1'b1;
      tick();
      check("r2 rhb3_ce", 32'(rhb3_ce), 32'(1));
      check("r2 rhb2_ce", 32'(rhb2_ce), 32'(1));
      check("r2 out_valid", 32'(out_valid), 32'(n > 64 && n % 2 == 0));
      in_valid = 1'b0;
      tick();
      check("r2 gap rhb3_ce", 32'(rhb3_ce), 32'(0));
      check("r2 gap out_valid", 32'(out_valid), 32'(0));
      tick();
      check("r2 gap2 rhb2_ce", 32'(rhb2_ce), 32'(0));
    end
    check("r2 out_cnt", 32'(out_cnt), 32'(4));
    check("r2 dec_ratio", 32'(dec_ratio), 32'(2));

    // Ratio 1 (both bypassed).
    enable = 1'b0;
    tick();
    bypass_rhb3 = 1'b1; bypass_rhb2 = 1'b1;
    tick();
    check("r1 dec_ratio", 32'(dec_ratio), 32'(1));
    enable = 1'b1;
    tick();
    in_valid = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      check("r1 rhb2_ce", 32'(rhb2_ce), 32'(1));
      check("r1 out_valid", 32'(out_valid), 32'(n > 64));
    end
    check("r1 out_cnt", 32'(out_cnt), 32'(6));

    // Asynchronous reset mid-RUN, well away from any clock edge.
    #3;
    reset = 1'b1;
    #1;
    check_idle("async");
    check("async out_cnt", 32'(out_cnt), 32'(0));
    check("async dec_ratio", 32'(dec_ratio), 32'(4));
    #1;
    reset = 1'b0;
    enable = 1'b0;

    // Narrow counter wrap on the CNT_W=4 instance (flush of 4, ratio 1).
    en_w = 1'b1;
    tick();
    check("w state", 32'(state_w), 32'(1));
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n <= 4) begin
        check("w flush out_valid", 32'(out_valid_w), 32'(0));
      end else begin
        check("w out_valid", 32'(out_valid_w), 32'(1));
        check("w out_cnt", 32'(out_cnt_w), 32'((n - 4) % 16));
      end
    end
    check("w out_cnt final", 32'(out_cnt_w), 32'(1));
    check("main idle during w", 32'(state), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adrv9009_rsp_ctrl.md
Name: adrv9009_rsp_ctrl

Overview:
- Sequencer for the receive signal path decimation chain: RHB3 (decimate-by-2) feeding RHB2 (decimate-by-2).
- Generates per-stage clock enables from the input sample strobe. Applies the latched bypass configuration per stage.
- Holds the filters in reset while idle. Suppresses output-valid while filter pipelines flush after start-up.
- Sits beside the receive signal path top and drives its enables, filter reset and output-valid qualifier.

Parameters:
- FLUSH_SAMPLES, 64: number of accepted input samples after enable before out_valid may assert (covers combined filter group delay); legal range 1..65535.
- CNT_W, 16: width of the output sample counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run the chain, 0 = stop and hold filters in reset.
- in_valid  in  1  strobe; one input sample present this cycle.
- bypass_rhb3  in  1  config; 1 = RHB3 stage treated as decimate-by-1.
- bypass_rhb2  in  1  config; 1 = RHB2 stage treated as decimate-by-1.
- filt_rst  out  1  synchronous reset to both filter stages.
- rhb3_ce  out  1  clock enable to RHB3.
- rhb2_ce  out  1  clock enable to RHB2.
- out_valid  out  1  strobe; chain output sample valid.
- dec_ratio  out  3  active total decimation ratio: 1, 2 or 4.
- state  out  2  0 = IDLE, 1 = FLUSH, 2 = RUN.
- out_cnt  out  CNT_W  count of out_valid pulses since last entry to FLUSH; wraps.
- cfg_err  out  1  one-cycle pulse; bypass inputs changed while not IDLE.

Behaviour:
- Reset values:
  - state = IDLE, filt_rst = 1, rhb3_ce = 0, rhb2_ce = 0, out_valid = 0.
  - dec_ratio = 4, out_cnt = 0, cfg_err = 0.
  - Internal phase bits ph3 = 0, ph2 = 0; flush counter = 0; latched bypass = 0.
- All outputs are registered.
  - rhb3_ce, rhb2_ce and out_valid assert exactly 1 cycle after the in_valid that qualifies them.
- IDLE:
  - filt_rst = 1; all ce and out_valid = 0.
  - bypass inputs are latched every cycle; dec_ratio reflects them (4 >> (bypass_rhb3 + bypass_rhb2)).
  - enable = 1 → FLUSH next cycle. On that transition: filt_rst = 0, ph3 = ph2 = 0, flush counter = 0, out_cnt = 0.
- FLUSH and RUN common datapath sequencing, per in_valid = 1:
  - rhb3_ce pulses.
  - Stage-2 tick = bypass3 ? 1 : ph3. Then ph3 toggles; ph3 is held at 0 when bypassed.
  - rhb2_ce pulses on a stage-2 tick.
  - Output tick = stage-2 tick AND (bypass2 ? 1 : ph2). Then ph2 toggles on each stage-2 tick; ph2 is held at 0 when bypassed.
  - Result: the first output tick is on the 4th, 2nd or 1st input for ratio 4, 2 or 1.
  - With in_valid = 0 there are no pulses and phases hold.
- FLUSH:
  - The flush counter increments per in_valid. Output ticks are suppressed: out_valid = 0.
  - When the counter reaches FLUSH_SAMPLES (on the cycle of the FLUSH_SAMPLES-th in_valid) → RUN.
  - The phase bits continue across the transition; they are not reset.
- RUN:
  - An output tick drives out_valid = 1 next cycle and increments out_cnt (wraps 2^CNT_W-1 → 0).
- enable = 0 in FLUSH or RUN:
  - Next cycle state = IDLE, filt_rst = 1, all ce/out_valid = 0.
  - Any in_valid on the same cycle as the enable drop is ignored.
  - out_cnt holds its value until the next start.
- Config changes:
  - In FLUSH or RUN, a change of either bypass input from its latched value is ignored. The latched config keeps operating.
  - cfg_err pulses 1 cycle, once per change edge.
- enable toggle 1 → 0 → 1 on consecutive cycles: IDLE is entered for 1 cycle; a full restart with a new flush follows.
- Asynchronous reset mid-operation: immediate return to the reset values above, independent of clk.

Test Plan:
- Reset asserted mid-RUN → state = 0, filt_rst = 1, all ce/out_valid = 0 and out_cnt = 0 immediately, without a clk edge.
- bypass = 00, enable = 1, in_valid continuous, FLUSH_SAMPLES = 64 → rhb3_ce every cycle, rhb2_ce every 2nd cycle, no out_valid for the first 64 inputs, then out_valid every 4th cycle; out_cnt = 10 after 40 further inputs; dec_ratio = 4.
- bypass = 10 (RHB3 bypassed), in_valid every 3rd cycle → rhb2_ce on every input, out_valid on every 2nd input after flush, 1-cycle latency; dec_ratio = 2.
- bypass = 11 → out_valid on every input in RUN; dec_ratio = 1.
- Toggle bypass_rhb2 during RUN → single cfg_err pulse; out_valid spacing unchanged.
- Drop enable on a cycle with in_valid = 1 in RUN → no ce/out_valid next cycle, filt_rst = 1, state = 0. Re-enable → 64-sample flush repeats, out_cnt restarts at 0.
- CNT_W = 4, 17 outputs in RUN → out_cnt wraps 15 → 0 and reads 1.
